// File: rtl/gf_serial_mul.sv
// rtl/gf_serial_mul.sv - bit-serial GF(2^M) polynomial-basis multiplier
//
// Computes Q = A * B mod POLY over GF(2^M). It processes one multiplier bit
// per clock, MSB first, so a result takes M+1 clocks from Start to Done.
//
// Parameters:
//   M     field degree, 2..16
//   POLY  irreducible field polynomial, M+1 bits, POLY[M] must be 1
//
// Ports:
//   Clk    clock; all state changes on the rising edge
//   Rst    synchronous active-high reset
//   Start  begin a multiplication (ignored while Busy)
//   A, B   operands in polynomial basis (bit i = coefficient of x^i)
//   Q      last completed product; held until the next completion
//   Busy   high while the multiply is iterating
//   Done   one-cycle pulse when Q has just been updated
module gf_serial_mul #(
  parameter int         M    = 3,
  parameter logic [M:0] POLY = 4'b1011
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] Q,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  generate
    if (M < 2 || M > 16) begin : g_bad_m
      $error("gf_serial_mul: M must be in 2..16");
    end
    if (POLY[M] != 1'b1) begin : g_bad_poly
      $error("gf_serial_mul: POLY[M] must be 1");
    end
  endgenerate

  logic [1:0]    state;
  logic [M-1:0]  acap;
  logic [M-1:0]  bcap;
  logic [M-1:0]  acc;
  logic [M-1:0]  acc_shift;
  logic [M-1:0]  acc_next;
  logic [CW-1:0] cnt;

  // Horner step: multiply the running sum by x (reducing the bit that would
  // reach degree M), then add A if the current multiplier bit is set.
  always_comb begin
    acc_shift = {acc[M-2:0], 1'b0};
    if (acc[M-1]) begin
      acc_shift = acc_shift ^ POLY[M-1:0];
    end
    acc_next = acc_shift;
    if (bcap[cnt]) begin
      acc_next = acc_shift ^ acap;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      acap  <= '0;
      bcap  <= '0;
      acc   <= '0;
      cnt   <= '0;
      Q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            acap  <= A;
            bcap  <= B;
            acc   <= '0;
            cnt   <= CW'(M - 1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          if (cnt == '0) begin
            Q     <= acc_next;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          // Accepting here gives back-to-back results every M+1 cycles.
          if (Start) begin
            acap  <= A;
            bcap  <= B;
            acc   <= '0;
            cnt   <= CW'(M - 1);
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state == ST_RUN);
  assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_gf_serial_mul.sv
// tb/tb_gf_serial_mul.sv - self-checking bench for gf_serial_mul (M=3 and M=4)
module tb_gf_serial_mul;

  logic       clk;
  logic       rst;
  logic       start3, start4;
  logic [2:0] a3, b3, q3;
  logic [3:0] a4, b4, q4;
  logic       busy3, done3, busy4, done4;

  int checks = 0;
  int errors = 0;

  gf_serial_mul #(.M(3), .POLY(4'b1011)) dut3 (
    .Clk(clk), .Rst(rst), .Start(start3), .A(a3), .B(b3),
    .Q(q3), .Busy(busy3), .Done(done3)
  );

  gf_serial_mul #(.M(4), .POLY(5'b10011)) dut4 (
    .Clk(clk), .Rst(rst), .Start(start4), .A(a4), .B(b4),
    .Q(q4), .Busy(busy4), .Done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full carry-less product, then long division by the polynomial.
  function automatic int gf_ref(input int a, input int b, input int m, input int poly);
    int p;
    p = 0;
    for (int i = 0; i < m; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    end
    for (int d = 2 * m - 2; d >= m; d--) begin
      if (((p >> d) & 1) != 0) p = p ^ (poly << (d - m));
    end
    return p;
  endfunction

  // Drive one Start pulse on dut3 and wait (bounded) for Done.
  task automatic mul3(input logic [2:0] a, input logic [2:0] b,
                      output logic [2:0] q, output int lat);
    @(negedge clk);
    a3 = a; b3 = b; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 1;
    while (done3 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = q3;
  endtask

  task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                      output logic [3:0] q, output int lat);
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = q4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q3 !== 3'd0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL reset3: q=%0d busy=%b done=%b, want q=0 busy=0 done=0", q3, busy3, done3);
    end
    checks++;
    if (q4 !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: q=%0d busy=%b done=%b, want q=0 busy=0 done=0", q4, busy4, done4);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_timing();
    int nbusy;
    @(negedge clk);
    a3 = 3'd3; b3 = 3'd5; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy3 === 1'b1 && done3 === 1'b0) nbusy++;
      if (i < 2) @(negedge clk);
    end
    checks++;
    if (nbusy != 3) begin
      errors++;
      $display("FAIL basic_busy: busy cycles=%0d, want 3", nbusy);
    end
    @(negedge clk);
    checks++;
    if (done3 !== 1'b1 || busy3 !== 1'b0 || q3 !== 3'b100) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b q=%0d, want done=1 busy=0 q=4", done3, busy3, q3);
    end
    @(negedge clk);
    checks++;
    if (done3 !== 1'b0 || busy3 !== 1'b0 || q3 !== 3'b100) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b q=%0d, want done=0 busy=0 q=4", done3, busy3, q3);
    end
  endtask

  task automatic test_vectors();
    logic [2:0] ta [4] = '{3'd7, 3'd2, 3'd0, 3'd1};
    logic [2:0] tb [4] = '{3'd7, 3'd4, 3'd6, 3'd6};
    logic [2:0] tq [4] = '{3'd3, 3'd3, 3'd0, 3'd6};
    logic [2:0] q;
    int lat;
    for (int i = 0; i < 4; i++) begin
      mul3(ta[i], tb[i], q, lat);
      checks++;
      if (q !== tq[i] || lat != 4) begin
        errors++;
        $display("FAIL vector%0d: a=%0d b=%0d q=%0d lat=%0d, want q=%0d lat=4",
                 i, ta[i], tb[i], q, lat, tq[i]);
      end
    end
  endtask

  task automatic test_random_m3();
    logic [2:0] a, b, q;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      mul3(a, b, q, lat);
      checks++;
      if (q !== 3'(gf_ref(a, b, 3, 'b1011)) || lat != 4) begin
        errors++;
        $display("FAIL rand3: a=%0d b=%0d q=%0d lat=%0d, want q=%0d lat=4",
                 a, b, q, lat, gf_ref(a, b, 3, 'b1011));
      end
    end
  endtask

  task automatic test_m4_exhaustive();
    logic [3:0] q;
    int lat;
    int bad;
    mul4(4'd2, 4'd8, q, lat);
    checks++;
    if (q !== 4'b0011 || lat != 5) begin
      errors++;
      $display("FAIL m4_basic: q=%0d lat=%0d, want q=3 lat=5", q, lat);
    end
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mul4(4'(a), 4'(b), q, lat);
        checks++;
        if (q !== 4'(gf_ref(a, b, 4, 'b10011)) || lat != 5) begin
          errors++;
          bad++;
          if (bad <= 8)
            $display("FAIL m4_pair: a=%0d b=%0d q=%0d lat=%0d, want q=%0d lat=5",
                     a, b, q, lat, gf_ref(a, b, 4, 'b10011));
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [2:0] prev_q;
    logic [2:0] want;
    int lat;
    @(negedge clk);
    prev_q = q3;
    a3 = 3'd6; b3 = 3'd3; start3 = 1'b1;
    want = 3'(gf_ref(6, 3, 3, 'b1011));
    @(negedge clk);
    lat = 1;
    // Toggle Start and scramble operands while busy; none of it may matter.
    while (done3 !== 1'b1 && lat < 20) begin
      checks++;
      if (q3 !== prev_q) begin
        errors++;
        $display("FAIL hold_q: q=%0d during run, want %0d", q3, prev_q);
      end
      start3 = lat[0];
      a3 = 3'($urandom_range(0, 7));
      b3 = 3'($urandom_range(0, 7));
      @(negedge clk);
      lat++;
    end
    start3 = 1'b0;
    checks++;
    if (q3 !== want || lat != 4) begin
      errors++;
      $display("FAIL start_ignored: q=%0d lat=%0d, want q=%0d lat=4", q3, lat, want);
    end
    @(negedge clk);
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || q3 !== want) begin
      errors++;
      $display("FAIL post_ignore: busy=%b done=%b q=%0d, want busy=0 done=0 q=%0d",
               busy3, done3, q3, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] opa [24];
    logic [2:0] opb [24];
    logic [2:0] want;
    for (int e = 0; e < 24; e++) begin
      opa[e] = 3'($urandom_range(0, 7));
      opb[e] = 3'($urandom_range(0, 7));
      a3 = opa[e]; b3 = opb[e]; start3 = 1'b1;
      @(negedge clk);
      checks++;
      if (done3 !== (e % 4 == 3) || busy3 !== (e % 4 != 3)) begin
        errors++;
        $display("FAIL b2b_flags: edge %0d done=%b busy=%b, want done=%b busy=%b",
                 e, done3, busy3, (e % 4 == 3), (e % 4 != 3));
      end
      if (e % 4 == 3) begin
        want = 3'(gf_ref(opa[e-3], opb[e-3], 3, 'b1011));
        checks++;
        if (q3 !== want) begin
          errors++;
          $display("FAIL b2b_q: edge %0d q=%0d, want %0d", e, q3, want);
        end
      end
    end
    start3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_rst_mid_run();
    logic [2:0] q;
    int lat;
    int seen_done;
    @(negedge clk);
    a3 = 3'd7; b3 = 3'd5; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || q3 !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b q=%0d, want busy=0 done=0 q=0", busy3, done3, q3);
    end
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done3 !== 1'b0 || busy3 !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL rst_abort: activity cycles after abort=%0d, want 0", seen_done);
    end
    mul3(3'd3, 3'd5, q, lat);
    checks++;
    if (q !== 3'd4 || lat != 4) begin
      errors++;
      $display("FAIL rst_restart: q=%0d lat=%0d, want q=4 lat=4", q, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    start3 = 1'b0; start4 = 1'b0;
    a3 = '0; b3 = '0; a4 = '0; b4 = '0;
    test_reset();
    test_basic_timing();
    test_vectors();
    test_random_m3();
    test_m4_exhaustive();
    test_start_ignored();
    test_back_to_back();
    test_rst_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf_serial_mul.md
GF_SERIAL_MUL -- requirements
Module: gf_serial_mul

Interface
REQ-001 The block SHALL have parameter M, default 3, giving the field size GF(2^M); legal range 2..16.
REQ-002 The block SHALL have parameter POLY, default 4'b1011 (x^3+x+1), width M+1, giving the irreducible field polynomial with POLY[M] = 1.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port Start, input, 1 bit: request to begin a multiplication.
REQ-006 The block SHALL have port A, input, M bits: multiplicand, polynomial basis, bit i = coefficient of x^i.
REQ-007 The block SHALL have port B, input, M bits: multiplier, same encoding as A.
REQ-008 The block SHALL have port Q, output, M bits: reduced product A*B mod POLY.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while a multiplication is in progress.
REQ-010 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking Q valid with a new result.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE, a rising edge with Start=1 SHALL capture A and B into internal registers, clear the accumulator, load bit counter = M-1 and enter RUN.
REQ-013 Each RUN edge SHALL compute acc_next = reduce(acc<<1) XOR (Bcap[cnt] ? Acap : 0), MSB-first; reduce() XORs POLY[M-1:0] when the shifted-out bit acc[M-1] = 1.
REQ-014 The RUN edge with cnt = 0 SHALL write acc_next to Q and enter DONE; other RUN edges SHALL decrement cnt.
REQ-015 Latency SHALL be exactly M+1 edges: Start accepted at edge k gives Done=1 during the cycle after edge k+M.
REQ-016 Busy SHALL be 1 exactly while in RUN; Done SHALL be 1 exactly while in DONE (one cycle).
REQ-017 DONE SHALL last one cycle; with Start=1 at that edge the FSM SHALL capture new operands and enter RUN (back-to-back, throughput one result per M+1 cycles); otherwise it SHALL return to IDLE.
REQ-018 Start during RUN SHALL be ignored; the operation in progress and its captured operands SHALL be unaffected.
REQ-019 Changes on A/B after capture SHALL NOT affect the result.
REQ-020 Q SHALL hold its last result until the next completion and SHALL change only on the edge entering DONE.
REQ-021 Arithmetic SHALL be carry-less (XOR only); Q SHALL always be fully reduced (degree < M).
REQ-022 An elaboration-time check SHALL flag POLY[M] = 0 or M outside 2..16 as an error.

Reset
REQ-023 Rst=1 at an edge SHALL force state IDLE, Q=0, Busy=0, Done=0, and clear acc, cnt and the operand registers, taking priority over Start.
REQ-024 Rst asserted mid-RUN SHALL abort the operation with no Done pulse; Q SHALL read 0.
REQ-025 After Rst deasserts, the first edge with Start=1 SHALL be accepted normally.

Verification
REQ-026 Test: M=3, POLY=1011, A=3, B=5, Start one cycle -> Busy for 3 cycles, then Done pulse with Q=3'b100.
REQ-027 Test: M=3, A=7, B=7 -> Q=3; A=2, B=4 -> Q=3; A=0, B=6 -> Q=0; A=1, B=6 -> Q=6.
REQ-028 Test: M=4, POLY=10011, A=2, B=8 -> Q=4'b0011 after 5 edges; exhaustive 256 pairs match the reference model.
REQ-029 Test: Start held high continuously, operands changing every cycle -> Done every 4 cycles (M=3); each Q equals the product of the operands present at the accepting edge; Start pulses during Busy are ignored.
REQ-030 Test: Rst=1 on the second RUN cycle -> next cycle IDLE, Q=0, Busy=0, no Done; a subsequent Start with A=3, B=5 -> Q=4.
